// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with simultaneous read/write,
//            almost-full/almost-empty flags, occupancy output, synchronous
//            flush and sticky overflow/underflow flags. Define
//            SYNC_FIFO_FWFT_EN for first-word-fall-through read mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       EN,
  input  logic                       CLR,
  input  logic                       WR,
  input  logic [WIDTH-1:0]           dataIn,
  input  logic                       RD,
  output logic [WIDTH-1:0]           dataOut,
  output logic                       dataValid,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       ALMOST_FULL,
  output logic                       ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  localparam logic [c_aw-1:0] c_ptr_one = 1;
  localparam logic [c_cw-1:0] c_cnt_one = 1;
  localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_af      = c_cw'(AF_THRESH);
  localparam logic [c_cw-1:0] c_ae      = c_cw'(AE_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_cw-1:0]  r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_rd_ok;
  logic             w_wr_ok;

  // Flags derive from the registered occupancy only, never from pointers.
  assign EMPTY        = (r_count == '0);
  assign FULL         = (r_count == c_depth);
  assign ALMOST_FULL  = (r_count >= c_af);
  assign ALMOST_EMPTY = (r_count <= c_ae);
  assign Count        = r_count;
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_unf;

  // A full FIFO can still accept a write when a read frees a slot this edge.
  assign w_rd_ok = RD & ~EMPTY;
  assign w_wr_ok = WR & (~FULL | w_rd_ok);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (EN) begin
      if (CLR) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
        r_unf    <= 1'b0;
      end else begin
        if (w_wr_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
        if (w_rd_ok) r_rd_ptr <= r_rd_ptr + c_ptr_one;
        case ({w_wr_ok, w_rd_ok})
          2'b10:   r_count <= r_count + c_cnt_one;
          2'b01:   r_count <= r_count - c_cnt_one;
          default: r_count <= r_count;
        endcase
        if (WR & ~w_wr_ok) r_ovf <= 1'b1;
        if (RD & ~w_rd_ok) r_unf <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge Clk) begin
    if (EN && !CLR && w_wr_ok) r_mem[r_wr_ptr] <= dataIn;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dataOut   = r_mem[r_rd_ptr];
  assign dataValid = ~EMPTY;
`else
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (EN) begin
      if (CLR) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_rd_ok;
        if (w_rd_ok) r_dout <= r_mem[r_rd_ptr];
      end
    end
  end

  assign dataOut   = r_dout;
  assign dataValid = r_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed self-checking bench for sync_fifo_param (DEPTH=8, WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        EN  = 1'b1;
  logic        CLR = 1'b0;
  logic        WR  = 1'b0;
  logic        RD  = 1'b0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;
  logic        dataValid, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
  logic [3:0]  Count;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_param #(.WIDTH(32), .DEPTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .EN(EN), .CLR(CLR), .WR(WR), .dataIn(dataIn), .RD(RD),
    .dataOut(dataOut), .dataValid(dataValid), .EMPTY(EMPTY), .FULL(FULL),
    .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .Count(Count),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    WR = 1'b1; dataIn = d;
    tick();
    WR = 1'b0;
  endtask

  task automatic pop();
    RD = 1'b1;
    tick();
    RD = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_word;
    logic [31:0] last_out;

    // Reset state before any clock edge
    #1;
    check("rst_count", 32'(Count), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full",  32'(FULL), 32'd0);
    check("rst_ae",    32'(ALMOST_EMPTY), 32'd1);
    check("rst_af",    32'(ALMOST_FULL), 32'd0);
    check("rst_valid", 32'(dataValid), 32'd0);
    check("rst_ovf",   32'(OVERFLOW), 32'd0);
    check("rst_unf",   32'(UNDERFLOW), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_dout",  dataOut, 32'd0);
`endif
    @(negedge Clk);
    Rst = 1'b0;

`ifndef SYNC_FIFO_FWFT_EN
    // Fill 1..8 with flag tracking
    for (int i = 1; i <= 8; i++) begin
      push(32'(i));
      check("fill_count", 32'(Count), 32'(i));
      check("fill_af", 32'(ALMOST_FULL), (i >= 6) ? 32'd1 : 32'd0);
      check("fill_ae", 32'(ALMOST_EMPTY), (i <= 2) ? 32'd1 : 32'd0);
      check("fill_full", 32'(FULL), (i == 8) ? 32'd1 : 32'd0);
    end

    // Full with RD&WR: both accepted
    RD = 1'b1; WR = 1'b1; dataIn = 32'hAA;
    tick();
    RD = 1'b0; WR = 1'b0;
    check("fullrw_count", 32'(Count), 32'd8);
    check("fullrw_ovf",   32'(OVERFLOW), 32'd0);
    check("fullrw_dout",  dataOut, 32'd1);
    check("fullrw_valid", 32'(dataValid), 32'd1);

    // Write at full is dropped
    push(32'hDD);
    check("ovf_flag",  32'(OVERFLOW), 32'd1);
    check("ovf_count", 32'(Count), 32'd8);
    check("ovf_valid", 32'(dataValid), 32'd0);

    // Drain: contents 2..8, AA in order, DD never stored
    for (int i = 0; i < 8; i++) begin
      exp_word = (i < 7) ? 32'(i + 2) : 32'hAA;
      pop();
      check("drain_dout",  dataOut, exp_word);
      check("drain_valid", 32'(dataValid), 32'd1);
    end
    tick();
    check("drain_empty",  32'(EMPTY), 32'd1);
    check("drain_valid0", 32'(dataValid), 32'd0);
    check("ovf_sticky",   32'(OVERFLOW), 32'd1);
    check("drain_hold",   dataOut, 32'hAA);

    // Empty with RD&WR: write accepted, read refused
    RD = 1'b1; WR = 1'b1; dataIn = 32'hBB;
    tick();
    RD = 1'b0; WR = 1'b0;
    check("emptyrw_count", 32'(Count), 32'd1);
    check("emptyrw_unf",   32'(UNDERFLOW), 32'd1);
    check("emptyrw_valid", 32'(dataValid), 32'd0);
    pop();
    check("emptyrw_dout", dataOut, 32'hBB);
    check("emptyrw_v",    32'(dataValid), 32'd1);

    // Flush
    push(32'h11);
    push(32'h22);
    CLR = 1'b1; RD = 1'b1; WR = 1'b1; dataIn = 32'h33;
    tick();
    CLR = 1'b0; RD = 1'b0; WR = 1'b0;
    check("clr_count", 32'(Count), 32'd0);
    check("clr_ovf",   32'(OVERFLOW), 32'd0);
    check("clr_unf",   32'(UNDERFLOW), 32'd0);
    check("clr_empty", 32'(EMPTY), 32'd1);
    check("clr_dout",  dataOut, 32'd0);
    check("clr_valid", 32'(dataValid), 32'd0);
    push(32'hCC);
    pop();
    check("clr_readback", dataOut, 32'hCC);

    // Wrap-around with 3-deep occupancy
    for (int i = 0; i < 3; i++) begin
      push(32'h100 + 32'(i));
      q.push_back(32'h100 + 32'(i));
    end
    for (int i = 0; i < 20; i++) begin
      RD = 1'b1; WR = 1'b1; dataIn = 32'h200 + 32'(i);
      tick();
      exp_word = q.pop_front();
      q.push_back(32'h200 + 32'(i));
      check("wrap_dout",  dataOut, exp_word);
      check("wrap_count", 32'(Count), 32'd3);
    end
    RD = 1'b0; WR = 1'b0;
    check("wrap_ovf", 32'(OVERFLOW), 32'd0);
    check("wrap_unf", 32'(UNDERFLOW), 32'd0);
    last_out = dataOut;

    // EN gating: everything held
    EN = 1'b0; RD = 1'b1; WR = 1'b1; CLR = 1'b1; dataIn = 32'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_count", 32'(Count), 32'd3);
      check("en_valid", 32'(dataValid), 32'd1);
      check("en_dout",  dataOut, last_out);
      check("en_flags", {26'd0, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW}, 32'd0);
    end
    EN = 1'b1; RD = 1'b0; WR = 1'b0; CLR = 1'b0;
    pop();
    check("en_after_pop", dataOut, q.pop_front());

    // Async reset mid-cycle, then normal operation on the next edge
    @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("arst_count", 32'(Count), 32'd0);
    check("arst_empty", 32'(EMPTY), 32'd1);
    check("arst_full",  32'(FULL), 32'd0);
    check("arst_dout",  dataOut, 32'd0);
    check("arst_valid", 32'(dataValid), 32'd0);
    check("arst_ovf",   32'(OVERFLOW), 32'd0);
    #1 Rst = 1'b0;
    push(32'h77);
    check("arst_wr_count", 32'(Count), 32'd1);
    pop();
    check("arst_readback", dataOut, 32'h77);
`else
    // First-word-fall-through
    push(32'h55);
    check("fwft_dout",  dataOut, 32'h55);
    check("fwft_valid", 32'(dataValid), 32'd1);
    check("fwft_empty", 32'(EMPTY), 32'd0);
    pop();
    check("fwft_pop_empty", 32'(EMPTY), 32'd1);
    check("fwft_pop_valid", 32'(dataValid), 32'd0);
    check("fwft_pop_count", 32'(Count), 32'd0);
    for (int i = 1; i <= 3; i++) push(32'(i) * 32'h10);
    check("fwft_count3", 32'(Count), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      check("fwft_head", dataOut, 32'(i) * 32'h10);
      pop();
    end
    check("fwft_drained", 32'(EMPTY), 32'd1);
    pop();
    check("fwft_unf", 32'(UNDERFLOW), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO for the cache datapath (fill/writeback staging, request queues).
- Generalises the fixed 32x32 buffer in width and depth.
- Adds simultaneous read/write, programmable almost-full/almost-empty flags, occupancy output, synchronous flush, and sticky overflow/underflow error flags.
- Registered read data with a valid strobe; optional first-word-fall-through mode.

Parameters:
- WIDTH, 32: data word width in bits, >= 1.
- DEPTH, 32: number of entries; power of two, >= 2.
- AF_THRESH, DEPTH-2: ALMOST_FULL asserts when Count >= AF_THRESH.
- AE_THRESH, 2: ALMOST_EMPTY asserts when Count <= AE_THRESH.

Ports:
- Clk  in  1  clock, all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- EN  in  1  clock enable. 0 = no state change except Rst; outputs hold.
- CLR  in  1  synchronous flush, effective when EN=1.
- WR  in  1  write request.
- dataIn  in  WIDTH  write data.
- RD  in  1  read request.
- dataOut  out  WIDTH  read data.
- dataValid  out  1  dataOut carries a newly popped word this cycle.
- EMPTY  out  1  Count == 0.
- FULL  out  1  Count == DEPTH.
- ALMOST_FULL  out  1  Count >= AF_THRESH.
- ALMOST_EMPTY  out  1  Count <= AE_THRESH.
- Count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- OVERFLOW  out  1  sticky: a write was dropped.
- UNDERFLOW  out  1  sticky: a read was refused.

Behaviour:
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. No compare-and-clear logic.
- Count is a registered up/down counter. It is never derived from pointer subtraction.
- Reset (async, Rst=1), all outputs and state take these values:
  - pointers = 0, Count = 0, dataOut = 0, dataValid = 0, OVERFLOW = 0, UNDERFLOW = 0.
  - EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = (AF_THRESH == 0).
  - Storage array is not cleared.
- Reset mid-operation discards all contents. The first edge after Rst deasserts operates normally.
- Priority when EN=1: CLR > read/write.
  - CLR: same values as reset, except storage is untouched. Concurrent RD/WR are ignored.
- Accept rules, evaluated on pre-edge state:
  - rd_ok = RD & ~EMPTY.
  - wr_ok = WR & (~FULL | rd_ok).
- Count update:
  - wr_ok only: Count+1.
  - rd_ok only: Count-1.
  - Both: Count unchanged; both pointers advance.
- Simultaneous events:
  - Empty with RD&WR: the write is accepted, the read is refused (UNDERFLOW sets).
  - Full with RD&WR: both are accepted; Count stays DEPTH.
- Standard-mode read latency is 1 cycle. On rd_ok, at the same edge:
  - dataOut <= mem[rd_ptr] and dataValid <= 1.
  - Otherwise dataValid <= 0 and dataOut holds its last value.
- Write: on wr_ok, mem[wr_ptr] <= dataIn.
- Error flags:
  - WR & ~wr_ok sets OVERFLOW.
  - RD & ~rd_ok sets UNDERFLOW.
  - Both are cleared only by Rst or CLR.
  - The dropped or refused operation has no other effect.
- EN=0: RD, WR and CLR are ignored. dataValid holds its value. No flag changes.
- Flags EMPTY, FULL, ALMOST_* are combinational from registered Count.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through mode):
  - dataOut = mem[rd_ptr] combinationally; dataValid = ~EMPTY.
  - RD acts as pop/acknowledge of the presented word.
  - A word written into an empty FIFO appears on dataOut the cycle after the write edge.
  - The dataOut reset value is don't-care while EMPTY=1.
- Undefined: standard registered-read behaviour as above.

Test Plan:
- Reset/flags: Rst pulse mid-cycle, no clock edge -> Count=0, EMPTY=1, FULL=0, dataOut=0, OVERFLOW=0 immediately.
- Fill/drain, DEPTH=8, WIDTH=32:
  - Write 0x1..0x8 -> FULL=1 after 8th edge, ALMOST_FULL=1 from Count=6.
  - Read 8 -> dataOut 0x1..0x8 in order, one cycle after each RD, dataValid=1 each.
  - Then EMPTY=1.
- Wrap-around: 20 cycles of 1 write + 1 read, interleaved with 3-deep occupancy -> output sequence equals input sequence, no flags set.
- Simultaneous:
  - At Count=8, RD&WR with 0xAA -> Count stays 8, OVERFLOW=0.
  - At Count=0, RD&WR with 0xBB -> Count=1, UNDERFLOW=1, next read returns 0xBB.
- Errors and flush:
  - WR at FULL -> OVERFLOW=1 sticky, Count=8, contents unchanged.
  - CLR -> Count=0, OVERFLOW=0, next write 0xCC reads back 0xCC.
- EN gating: EN=0 with RD=WR=CLR=1 for 5 cycles at Count=3 -> Count=3, dataValid and all flags unchanged.
- FWFT build: write 0x55 into empty FIFO -> dataOut=0x55 and dataValid=1 next cycle with no RD; RD -> EMPTY=1 after the edge.
